fc_stream_feeder: RTL and testbench

Transmit-side sequencer for the fully-connected MAC kernel array. It captures one input activation vector of FAN_IN words. It then streams (activation, weight, bias, has_bias, neuron_id, valid) to a kernel for each of FAN_OUT neurons, reading weights and biases from external synchronous memories. It guarantees the gap-free valid stream and first-element bias flag that the kernel's fan-in counter and accumulator depend on.

---
 rtl/fc_stream_feeder.sv | 167 ++++++++++++++++
 tb/tb_fc_stream_feeder.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_stream_feeder.sv
// Purpose: captures one FAN_IN activation vector, then streams activation/weight/bias tuples for FAN_OUT neurons.
// Latency: the first valid_o comes 2 cycles after the final accept; then FAN_IN*FAN_OUT gap-free beats, done_o one cycle later.
// Backpressure: in_ready drops for the whole stream phase; the kernel side has no stall and must accept every beat.

`ifndef PREC
`define PREC 16
`endif

module fc_stream_feeder #(
    parameter int FAN_IN       = 100,
    parameter int FAN_OUT      = 10,
    parameter int ID_WIDTH     = 4,
    parameter int W_ADDR_WIDTH = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic signed [`PREC-1:0]   in_data,
    output logic                      in_ready,
    output logic                      w_rd_en,
    output logic [W_ADDR_WIDTH-1:0]   w_addr,
    output logic [ID_WIDTH-1:0]       b_addr,
    input  logic signed [`PREC-1:0]   w_data,
    input  logic signed [`PREC-1:0]   b_data,
    output logic signed [`PREC-1:0]   activation_o,
    output logic signed [`PREC-1:0]   weight_o,
    output logic signed [`PREC-1:0]   bias_o,
    output logic                      has_bias_o,
    output logic [ID_WIDTH-1:0]       neuron_id_o,
    output logic                      valid_o,
    output logic                      done_o
);

    localparam int CNT_W = (FAN_IN > 1) ? $clog2(FAN_IN) : 1;
    localparam logic [CNT_W-1:0]    EL_LAST     = CNT_W'(FAN_IN - 1);
    localparam logic [ID_WIDTH-1:0] NEURON_LAST = ID_WIDTH'(FAN_OUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          ld_cnt_q, ld_cnt_d;
    logic [CNT_W-1:0]          el_q, el_d;
    logic [ID_WIDTH-1:0]       neuron_q, neuron_d;
    logic [W_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                      valid_q, valid_d;
    logic                      has_bias_q, has_bias_d;
    logic [ID_WIDTH-1:0]       nid_q, nid_d;
    logic signed [`PREC-1:0]   act_q, act_d;
    logic                      last_q, last_d;
    logic                      done_q, done_d;

    // Activation buffer holds no reset value; it is only read after a full load.
    logic signed [`PREC-1:0]   act_buf_q [FAN_IN];

    logic accept;
    logic issue;
    logic issue_last;

    assign accept     = in_valid && (state_q != STREAM);
    assign issue      = (state_q == STREAM);
    assign issue_last = issue && (el_q == EL_LAST) && (neuron_q == NEURON_LAST);

    // Next-state, counter and output-register computation for the load/stream sequencer.
    always_comb begin
        state_d    = state_q;
        ld_cnt_d   = ld_cnt_q;
        el_d       = el_q;
        neuron_d   = neuron_q;
        addr_d     = addr_q;
        nid_d      = nid_q;
        act_d      = act_q;
        valid_d    = issue;
        has_bias_d = issue && (el_q == '0);
        last_d     = issue_last;
        done_d     = last_q;

        case (state_q)
            IDLE, LOAD: begin
                if (accept) begin
                    if (ld_cnt_q == EL_LAST) begin
                        ld_cnt_d = '0;
                        state_d  = STREAM;
                    end else begin
                        ld_cnt_d = ld_cnt_q + 1'b1;
                        state_d  = LOAD;
                    end
                end
            end
            STREAM: begin
                // Capture what the kernel sees one cycle later, aligned with the memory read data.
                nid_d = neuron_q;
                act_d = act_buf_q[el_q];
                if (issue_last) begin
                    // Counters return to zero so the next stream starts from address 0.
                    el_d     = '0;
                    neuron_d = '0;
                    addr_d   = '0;
                    state_d  = IDLE;
                end else begin
                    addr_d = addr_q + 1'b1;
                    if (el_q == EL_LAST) begin
                        el_d     = '0;
                        neuron_d = neuron_q + 1'b1;
                    end else begin
                        el_d = el_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs with synchronous active-low reset; reset aborts any stream.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            ld_cnt_q   <= '0;
            el_q       <= '0;
            neuron_q   <= '0;
            addr_q     <= '0;
            valid_q    <= 1'b0;
            has_bias_q <= 1'b0;
            nid_q      <= '0;
            act_q      <= '0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ld_cnt_q   <= ld_cnt_d;
            el_q       <= el_d;
            neuron_q   <= neuron_d;
            addr_q     <= addr_d;
            valid_q    <= valid_d;
            has_bias_q <= has_bias_d;
            nid_q      <= nid_d;
            act_q      <= act_d;
            last_q     <= last_d;
            done_q     <= done_d;
        end
    end

    // Buffer write on every accepted word; stream phase never writes because accept is gated by state.
    always_ff @(posedge clk) begin
        if (accept) begin
            act_buf_q[ld_cnt_q] <= in_data;
        end
    end

    assign in_ready     = (state_q != STREAM);
    assign w_rd_en      = (state_q == STREAM);
    assign w_addr       = addr_q;
    assign b_addr       = neuron_q;
    assign weight_o     = w_data;
    assign bias_o       = b_data;
    assign activation_o = act_q;
    assign has_bias_o   = has_bias_q;
    assign neuron_id_o  = nid_q;
    assign valid_o      = valid_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_fc_stream_feeder.sv
`ifndef PREC
`define PREC 16
`endif

module tb_fc_stream_feeder;

    localparam int FI = 4;
    localparam int FO = 3;
    localparam int IW = 4;
    localparam int AW = 4;
    localparam int DW = `PREC;
    localparam int NT = FI * FO;

    typedef struct packed {
        logic [DW-1:0] act;
        logic [DW-1:0] w;
        logic [DW-1:0] b;
        logic          hb;
        logic [IW-1:0] nid;
    } elem_t;

    typedef logic [FI-1:0][DW-1:0] vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          w_rd_en;
    logic [AW-1:0] w_addr;
    logic [IW-1:0] b_addr;
    logic [DW-1:0] w_data = '0;
    logic [DW-1:0] b_data = '0;
    logic [DW-1:0] activation_o;
    logic [DW-1:0] weight_o;
    logic [DW-1:0] bias_o;
    logic          has_bias_o;
    logic [IW-1:0] neuron_id_o;
    logic          valid_o;
    logic          done_o;

    int total = 0;
    int bad   = 0;

    fc_stream_feeder #(
        .FAN_IN(FI), .FAN_OUT(FO), .ID_WIDTH(IW), .W_ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .w_rd_en(w_rd_en), .w_addr(w_addr), .b_addr(b_addr), .w_data(w_data), .b_data(b_data),
        .activation_o(activation_o), .weight_o(weight_o), .bias_o(bias_o),
        .has_bias_o(has_bias_o), .neuron_id_o(neuron_id_o), .valid_o(valid_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    // Synchronous memories whose content equals their address.
    always @(posedge clk) begin
        if (w_rd_en === 1'b1) begin
            w_data <= DW'(w_addr);
            b_data <= DW'(b_addr);
        end
    end

    // Observation log, sampled on the falling edge.
    int    cyc = 0;
    elem_t vq[$];
    int    vc[$];
    int    rq[$];
    int    bq[$];
    int    rc[$];
    int    aq[$];
    int    ac[$];
    int    dc[$];
    int    hb_stray = 0;
    int    ir_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        elem_t e;
        if (valid_o === 1'b1) begin
            e.act = activation_o; e.w = weight_o; e.b = bias_o;
            e.hb = has_bias_o; e.nid = neuron_id_o;
            vq.push_back(e);
            vc.push_back(cyc);
        end
        if (w_rd_en === 1'b1) begin
            rq.push_back(int'(w_addr));
            bq.push_back(int'(b_addr));
            rc.push_back(cyc);
        end
        if (rst === 1'b1 && in_valid === 1'b1 && in_ready === 1'b1) begin
            aq.push_back(int'(in_data));
            ac.push_back(cyc);
        end
        if (done_o === 1'b1) dc.push_back(cyc);
        if (has_bias_o === 1'b1 && valid_o !== 1'b1) hb_stray++;
        if (in_ready === 1'b1 && w_rd_en === 1'b1) ir_bad++;
    end

    // Reference: beat k carries element k%FI of neuron k/FI; memories return their address.
    function automatic elem_t exp_elem(input vec_t v, input int k);
        elem_t e;
        e.act = v[k % FI];
        e.w   = DW'(k);
        e.b   = DW'(k / FI);
        e.hb  = (k % FI) == 0;
        e.nid = IW'(k / FI);
        return e;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int i = 0; i < FI; i++) v[i] = DW'($urandom_range(100, 65535));
        return v;
    endfunction

    task automatic clear_mon();
        vq.delete(); vc.delete(); rq.delete(); bq.delete(); rc.delete();
        aq.delete(); ac.delete(); dc.delete();
        hb_stray = 0; ir_bad = 0;
    endtask

    // Offers each word until accepted; gap<0 inserts random idle cycles between words.
    task automatic load_vec(input vec_t v, input int gap, output bit ok);
        ok = 1'b1;
        for (int i = 0; i < FI; i++) begin
            int g;
            bit acc;
            int n;
            g = (gap < 0) ? int'($urandom_range(0, 2)) : ((i == 0) ? 0 : gap);
            in_valid = 1'b0;
            repeat (g) begin @(posedge clk); #1; end
            in_valid = 1'b1;
            in_data  = v[i];
            acc = 1'b0;
            n = 0;
            while (!acc && n < 100) begin
                acc = (in_ready === 1'b1);
                @(posedge clk); #1;
                n++;
            end
            if (!acc) ok = 1'b0;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int n, output bit ok);
        for (int i = 0; i < 400; i++) begin
            if (dc.size() >= n) break;
            @(posedge clk); #1;
        end
        ok = (dc.size() >= n);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (in_ready !== 1'b1)      begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (w_rd_en !== 1'b0)       begin bad++; $display("FAIL reset_w_rd_en got=%b want=0", w_rd_en); end
        total++; if (w_addr !== '0)          begin bad++; $display("FAIL reset_w_addr got=%0d want=0", w_addr); end
        total++; if (b_addr !== '0)          begin bad++; $display("FAIL reset_b_addr got=%0d want=0", b_addr); end
        total++; if (valid_o !== 1'b0)       begin bad++; $display("FAIL reset_valid got=%b want=0", valid_o); end
        total++; if (has_bias_o !== 1'b0)    begin bad++; $display("FAIL reset_has_bias got=%b want=0", has_bias_o); end
        total++; if (neuron_id_o !== '0)     begin bad++; $display("FAIL reset_neuron_id got=%0d want=0", neuron_id_o); end
        total++; if (activation_o !== '0)    begin bad++; $display("FAIL reset_activation got=%0d want=0", activation_o); end
        total++; if (done_o !== 1'b0)        begin bad++; $display("FAIL reset_done got=%b want=0", done_o); end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_stream();
        vec_t v;
        bit ok;
        int bub;
        v[0] = 10; v[1] = 11; v[2] = 12; v[3] = 13;
        clear_mon();
        load_vec(v, 1, ok);
        total++; if (!ok) begin bad++; $display("FAIL stream_load_timeout got=0 want=1"); end
        wait_done(1, ok);
        total++; if (!ok) begin bad++; $display("FAIL stream_done_timeout got=%0d want=1", dc.size()); end
        repeat (3) begin @(posedge clk); #1; end
        total++; if (ac.size() != FI || ac[FI-1] - ac[0] != 6)
            begin bad++; $display("FAIL stream_accepts got=%0d span=%0d want=%0d span=6", ac.size(), ac[FI-1] - ac[0], FI); end
        total++; if (rq.size() != NT) begin bad++; $display("FAIL stream_rd_count got=%0d want=%0d", rq.size(), NT); end
        total++; if (rc[0] != ac[FI-1] + 1) begin bad++; $display("FAIL stream_rd_start got=%0d want=%0d", rc[0], ac[FI-1] + 1); end
        for (int k = 0; k < rq.size() && k < NT; k++) begin
            total++;
            if (rq[k] != k || bq[k] != k / FI || rc[k] != rc[0] + k)
                begin bad++; $display("FAIL stream_addr[%0d] got=%0d/%0d@%0d want=%0d/%0d", k, rq[k], bq[k], rc[k], k, k / FI); end
        end
        total++; if (vq.size() != NT) begin bad++; $display("FAIL stream_valid_count got=%0d want=%0d", vq.size(), NT); end
        total++; if (vc[0] != ac[FI-1] + 2) begin bad++; $display("FAIL stream_first_valid got=%0d want=%0d", vc[0], ac[FI-1] + 2); end
        bub = 0;
        for (int k = 1; k < vc.size(); k++) if (vc[k] != vc[k-1] + 1) bub++;
        total++; if (bub != 0) begin bad++; $display("FAIL stream_bubbles got=%0d want=0", bub); end
        for (int k = 0; k < vq.size() && k < NT; k++) begin
            total++;
            if (vq[k] !== exp_elem(v, k))
                begin bad++; $display("FAIL stream_elem[%0d] got=%h want=%h", k, vq[k], exp_elem(v, k)); end
        end
        total++; if (dc.size() != 1 || dc[0] != vc[vc.size()-1] + 1)
            begin bad++; $display("FAIL stream_done got=%0d@%0d want=1@%0d", dc.size(), dc[0], vc[vc.size()-1] + 1); end
        total++; if (hb_stray != 0) begin bad++; $display("FAIL stream_hb_stray got=%0d want=0", hb_stray); end
        total++; if (neuron_id_o !== IW'(FO - 1)) begin bad++; $display("FAIL stream_nid_hold got=%0d want=%0d", neuron_id_o, FO - 1); end
    endtask

    task automatic test_hold_valid();
        vec_t v;
        vec_t n99;
        bit ok;
        int n;
        v = rand_vec();
        for (int i = 0; i < FI; i++) n99[i] = 99;
        clear_mon();
        load_vec(v, -1, ok);
        total++; if (!ok) begin bad++; $display("FAIL hold_load_timeout got=0 want=1"); end
        in_valid = 1'b1;
        in_data  = 99;
        n = 0;
        while (vq.size() <= NT && n < 200) begin @(negedge clk); n++; end
        in_valid = 1'b0;
        wait_done(2, ok);
        total++; if (!ok) begin bad++; $display("FAIL hold_done_timeout got=%0d want=2", dc.size()); end
        total++; if (aq.size() != 2 * FI) begin bad++; $display("FAIL hold_accepts got=%0d want=%0d", aq.size(), 2 * FI); end
        for (int i = FI; i < aq.size(); i++) begin
            total++; if (aq[i] != 99) begin bad++; $display("FAIL hold_acc_data[%0d] got=%0d want=99", i, aq[i]); end
        end
        total++; if (ac[FI] != vc[NT-1]) begin bad++; $display("FAIL hold_reaccept_cycle got=%0d want=%0d", ac[FI], vc[NT-1]); end
        total++; if (ir_bad != 0) begin bad++; $display("FAIL hold_in_ready_stream got=%0d want=0", ir_bad); end
        total++; if (vq.size() != 2 * NT) begin bad++; $display("FAIL hold_valid_count got=%0d want=%0d", vq.size(), 2 * NT); end
        for (int k = 0; k < vq.size() && k < 2 * NT; k++) begin
            elem_t e;
            e = (k < NT) ? exp_elem(v, k) : exp_elem(n99, k - NT);
            total++;
            if (vq[k] !== e) begin bad++; $display("FAIL hold_elem[%0d] got=%h want=%h", k, vq[k], e); end
        end
        total++; if (hb_stray != 0) begin bad++; $display("FAIL hold_hb_stray got=%0d want=0", hb_stray); end
    endtask

    task automatic test_back_to_back();
        vec_t a;
        vec_t b;
        bit ok;
        a = rand_vec();
        b = rand_vec();
        clear_mon();
        load_vec(a, 0, ok);
        total++; if (!ok) begin bad++; $display("FAIL b2b_load_a_timeout got=0 want=1"); end
        load_vec(b, 0, ok);
        total++; if (!ok) begin bad++; $display("FAIL b2b_load_b_timeout got=0 want=1"); end
        wait_done(2, ok);
        total++; if (!ok) begin bad++; $display("FAIL b2b_done_timeout got=%0d want=2", dc.size()); end
        total++; if (vq.size() != 2 * NT) begin bad++; $display("FAIL b2b_valid_count got=%0d want=%0d", vq.size(), 2 * NT); end
        total++; if (ac[FI] != vc[NT-1]) begin bad++; $display("FAIL b2b_first_idle_accept got=%0d want=%0d", ac[FI], vc[NT-1]); end
        total++; if (vc[NT] - vc[NT-1] < 2) begin bad++; $display("FAIL b2b_gap got=%0d want>=2", vc[NT] - vc[NT-1]); end
        total++; if (vc[NT] != ac[2*FI-1] + 2) begin bad++; $display("FAIL b2b_second_start got=%0d want=%0d", vc[NT], ac[2*FI-1] + 2); end
        for (int k = 0; k < vq.size() && k < 2 * NT; k++) begin
            elem_t e;
            e = (k < NT) ? exp_elem(a, k) : exp_elem(b, k - NT);
            total++;
            if (vq[k] !== e) begin bad++; $display("FAIL b2b_elem[%0d] got=%h want=%h", k, vq[k], e); end
        end
        total++; if (dc[0] != vc[NT-1] + 1 || dc[1] != vc[2*NT-1] + 1)
            begin bad++; $display("FAIL b2b_done_cycles got=%0d,%0d want=%0d,%0d", dc[0], dc[1], vc[NT-1] + 1, vc[2*NT-1] + 1); end
    endtask

    task automatic test_reset_mid();
        vec_t v;
        bit ok;
        int n;
        v = rand_vec();
        clear_mon();
        load_vec(v, -1, ok);
        total++; if (!ok) begin bad++; $display("FAIL rmid_load_timeout got=0 want=1"); end
        n = 0;
        while (vq.size() < 7 && n < 100) begin @(negedge clk); n++; end
        total++; if (vq.size() != 7) begin bad++; $display("FAIL rmid_reach_elem6 got=%0d want=7", vq.size()); end
        rst = 1'b0;
        @(posedge clk); #1;
        total++; if (valid_o !== 1'b0)  begin bad++; $display("FAIL rmid_valid got=%b want=0", valid_o); end
        total++; if (w_rd_en !== 1'b0)  begin bad++; $display("FAIL rmid_w_rd_en got=%b want=0", w_rd_en); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rmid_in_ready got=%b want=1", in_ready); end
        rst = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        total++; if (dc.size() != 0) begin bad++; $display("FAIL rmid_no_done got=%0d want=0", dc.size()); end
        v = rand_vec();
        clear_mon();
        load_vec(v, -1, ok);
        total++; if (!ok) begin bad++; $display("FAIL rmid_reload_timeout got=0 want=1"); end
        wait_done(1, ok);
        total++; if (!ok) begin bad++; $display("FAIL rmid_done_timeout got=%0d want=1", dc.size()); end
        total++; if (vq.size() != NT) begin bad++; $display("FAIL rmid_valid_count got=%0d want=%0d", vq.size(), NT); end
        total++; if (vc[0] != ac[FI-1] + 2) begin bad++; $display("FAIL rmid_first_valid got=%0d want=%0d", vc[0], ac[FI-1] + 2); end
        for (int k = 0; k < vq.size() && k < NT; k++) begin
            total++;
            if (vq[k] !== exp_elem(v, k)) begin bad++; $display("FAIL rmid_elem[%0d] got=%h want=%h", k, vq[k], exp_elem(v, k)); end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_hold_valid();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
